// File: rtl/tdm_voice_sequencer.sv
// Double-buffered 8-voice sample bank emitted as a TDM {chan, data} stream, one voice per enabled dsp_clk.
// Optional per-voice output mute (voice_mute port) is built only when TDM_SEQ_MUTE_EN is defined.
module tdm_voice_sequencer #(
  parameter int NUM_VOICES     = 8,
  parameter int NUM_VOICE_BITS = 3,
  parameter int D_W            = 16
) (
  input  logic                      dsp_clk,
  input  logic                      dsp_rst,
  input  logic                      dsp_enable,
  input  logic                      wr_en,
  input  logic [NUM_VOICE_BITS-1:0] wr_voice,
  input  logic [D_W-1:0]            wr_data,
  input  logic                      commit,
`ifdef TDM_SEQ_MUTE_EN
  input  logic [NUM_VOICES-1:0]     voice_mute,
`endif
  output logic [NUM_VOICE_BITS-1:0] chan_out,
  output logic [D_W-1:0]            data_out,
  output logic                      frame_start,
  output logic                      commit_pending
);

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  logic [D_W-1:0]            bank_a [NUM_VOICES];
  logic [D_W-1:0]            bank_b [NUM_VOICES];
  bank_e                     bank_sel;
  bank_e                     eff_sel;
  bank_e                     bank_sel_nxt;
  logic [NUM_VOICE_BITS-1:0] cnt;
  logic [NUM_VOICE_BITS-1:0] cnt_nxt;
  logic [NUM_VOICE_BITS-1:0] chan_nxt;
  logic [D_W-1:0]            rd_data;
  logic [D_W-1:0]            data_nxt;
  logic                      frame_start_nxt;
  logic                      pending_nxt;
  logic                      boundary;
  logic                      swap;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    cnt_nxt         = '0;
    chan_nxt        = '0;
    data_nxt        = '0;
    frame_start_nxt = 1'b0;
    eff_sel         = bank_sel;
    pending_nxt     = commit_pending;

    boundary = (cnt == '0) || !dsp_enable;
    swap     = boundary && (commit_pending || commit);

    // The read at a boundary already sees the post-swap bank, so channel 0 of a new frame is never stale.
    if (swap) begin
      eff_sel = (bank_sel == BANK_A) ? BANK_B : BANK_A;
    end
    bank_sel_nxt = eff_sel;

    if (swap) begin
      pending_nxt = 1'b0;
    end else if (commit) begin
      pending_nxt = 1'b1;
    end

    rd_data = (eff_sel == BANK_A) ? bank_a[cnt] : bank_b[cnt];
`ifdef TDM_SEQ_MUTE_EN
    if (voice_mute[cnt]) begin
      rd_data = '0;
    end
`endif

    // A disabled cycle parks the sequencer at channel 0 and drives silence downstream.
    if (dsp_enable) begin
      cnt_nxt         = cnt + NUM_VOICE_BITS'(1);
      chan_nxt        = cnt;
      data_nxt        = rd_data;
      frame_start_nxt = (cnt == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      cnt            <= '0;
      bank_sel       <= BANK_A;
      commit_pending <= 1'b0;
      chan_out       <= '0;
      data_out       <= '0;
      frame_start    <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      bank_sel       <= bank_sel_nxt;
      commit_pending <= pending_nxt;
      chan_out       <= chan_nxt;
      data_out       <= data_nxt;
      frame_start    <= frame_start_nxt;
    end
  end

  // NOTE: the banks are reset flops rather than a RAM because reset must clear every entry to zero.
  // Writes target the shadow of eff_sel, so a write in a swap cycle lands in the bank just retired.
  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (eff_sel == BANK_A) begin
        bank_b[wr_voice] <= wr_data;
      end else begin
        bank_a[wr_voice] <= wr_data;
      end
    end
  end

endmodule

// File: doc/tdm_voice_sequencer.md
# tdm_voice_sequencer

Producer end of the per-voice TDM sample stream. The block holds one 16-bit fix14_16 sample per voice in a double-buffered bank and emits them as a `{channel, data}` pair on every enabled `dsp_clk`, cycling channel 0..7. Its output drives the channel/data inputs of `sample_pipeline`. Voice generators write into a shadow bank at any time; a commit swaps banks atomically at the next frame boundary, so a frame is never torn.

## Interface
- `NUM_VOICES`, 8: voices per frame; fixed at 8.
- `NUM_VOICE_BITS`, 3: channel index width.
- `D_W`, 16: sample width, fix14_16.

- `dsp_clk` input 1: the single clock.
- `dsp_rst` input 1: reset, asynchronous, active-high.
- `dsp_enable` input 1: run the frame sequencer.
- `wr_en` input 1: write `wr_data` into the shadow bank at `wr_voice`.
- `wr_voice` input 3: shadow bank write index.
- `wr_data` input 16: shadow bank write data.
- `commit` input 1: single-cycle request to swap banks at the next frame boundary.
- `voice_mute` input 8: per-voice mute mask; present only with `TDM_SEQ_MUTE_EN`.
- `chan_out` output 3: TDM channel index.
- `data_out` output 16: sample for `chan_out`.
- `frame_start` output 1: high while `chan_out == 0` is presented by an enabled frame.
- `commit_pending` output 1: commit requested, swap not yet applied.

## Operation
- Storage: two banks of 8×16-bit registers, A and B. `bank_sel` chooses the active bank; the other bank is the shadow. `cnt[2:0]` is the next channel to emit.
- Reset values: `chan_out` = 0, `data_out` = 0, `frame_start` = 0, `commit_pending` = 0, `cnt` = 0, `bank_sel` = A, and all 16 bank entries are 0.
- Frame boundary: `cnt == 0`, or `dsp_enable` low.
- `swap` = boundary & (`commit_pending` | `commit`).
  - On `swap`, `bank_sel` toggles and `commit_pending` clears.
  - A `commit` that does not land on a boundary sets `commit_pending`.
  - A `commit` while already pending is a no-op. Only one swap is queued.
- Read at the boundary uses the post-swap selection: `eff_sel = bank_sel ^ swap`. Channel 0 of the new frame therefore already comes from the newly active bank.
- Write: `wr_en` writes the shadow bank relative to `eff_sel`. In a swap cycle the write lands in the old active bank, which is the new shadow, and never in the bank being emitted.
- Writes are legal in every cycle, enabled or not. Without a commit, a write is never visible on `data_out`.
- Enabled cycle:
  - `chan_out` <= `cnt`
  - `data_out` <= active[`cnt`]
  - `frame_start` <= (`cnt == 0`)
  - `cnt` <= `cnt + 1`, wrapping from 7 to 0
- Disabled cycle:
  - `cnt` <= 0
  - `chan_out` <= 0, `data_out` <= 0, `frame_start` <= 0
  - Any pending or concurrent commit is applied. Downstream therefore sees channel 0 with zero data and drains to silence.
- Re-enable always starts a fresh frame at channel 0.

## Timing
- Output latency is 1 `dsp_clk`: a registered `{chan, data}` pair appears on the edge after `cnt` selects it.
- The frame period is 8 enabled cycles. `frame_start` is high for 1 of every 8 enabled cycles.
- Commit to new data:
  - A `commit` asserted in a cycle with `cnt == 0` appears on `data_out` at the next edge.
  - Otherwise it appears at the edge after the next wrap, at most 8 cycles later.
  - A commit exactly on the boundary cycle does not raise `commit_pending`.
- Asynchronous reset mid-frame clears all outputs and banks immediately. The first post-reset enabled edge emits channel 0 with data 0.

## Configuration
- `TDM_SEQ_MUTE_EN` defined:
  - The `voice_mute` port exists.
  - `data_out` <= 0 when `voice_mute[cnt]` is set. `chan_out` and `frame_start` are unaffected.
  - The mask is sampled on the same edge as the read, with no latency.
  - Bank contents are untouched.
- `TDM_SEQ_MUTE_EN` undefined: the port is absent and every voice passes unmodified.

## Test plan
- Reset, then hold `dsp_enable` high -> `chan_out` 0,1,…,7,0 on consecutive edges; `data_out` is 0 throughout; `frame_start` is high on each channel-0 cycle.
- Write voices 0..7 = 16'h0100·(v+1), then commit mid-frame at `cnt == 3` -> `commit_pending` = 1 until the wrap; channel 0 of the next frame carries 16'h0100 and channel 7 carries 16'h0800; the frame in flight stays all 0.
- With bank A = 0x0100.., commit exactly on a `cnt == 0` cycle while writing voice 2 = 16'h7FFF -> the swap applies with no pending flag; the current frame shows voice 2 = 16'h0300; 16'h7FFF appears only after a second commit.
- Two commits within one frame -> exactly one swap; `commit_pending` clears once.
- Drop `dsp_enable` at `cnt == 5` -> next edge `chan_out` = 0, `data_out` = 0; re-enable -> sequence restarts at channel 0.
- Assert `dsp_rst` at `cnt == 4` with banks loaded -> outputs are 0 immediately; after release, every channel emits 0. With `TDM_SEQ_MUTE_EN`: `voice_mute` = 8'b0000_0100 -> channel 2 reads 0 while the other voices carry their stored values.
